// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Memory-side responder for the CPU bus. It holds the instruction memory
//   (IMEM) and the data memory (DMEM), serves CPU fetches, loads and stores,
//   and lets a host load programs through a ready/valid port. After reset,
//   both memories are zeroed. The CPU is held in reset until the host
//   signals that loading is done.
//
// Ports
//   CK        clock, rising edge
//   RST       asynchronous active-high reset
//   IA / ID   instruction address in, instruction word out (1-cycle latency)
//   DA / DD   data address in, bidirectional data bus (driven only when RW=1)
//   RW        1 = CPU read, 0 = CPU write
//   LD_*      host load port: LD_VALID/LD_SEL/LD_ADDR/LD_DATA with LD_READY,
//             LD_DONE releases the CPU, LD_START returns from RUN to LOAD
//   CPU_RST   active-high reset to the CPU, low only in RUN
//   ERR       sticky out-of-range CPU access flag, cleared only by RST
module cpu_mem_responder #(
    parameter int AW = 7,
    parameter int DW = 16
) (
    input  logic          CK,
    input  logic          RST,
    input  logic [15:0]   IA,
    output logic [DW-1:0] ID,
    input  logic [15:0]   DA,
    inout  wire  [DW-1:0] DD,
    input  logic          RW,
    input  logic          LD_VALID,
    input  logic          LD_SEL,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [DW-1:0] LD_DATA,
    output logic          LD_READY,
    input  logic          LD_DONE,
    input  logic          LD_START,
    output logic          CPU_RST,
    output logic          ERR
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] clr_cnt_reg;
    logic          ld_ready_reg;
    logic          cpu_rst_reg;
    logic          err_reg;

    // Validity flags qualify the raw RAM output registers. Because of this,
    // the RAM read path carries no reset. The outputs still show 0 whenever
    // the spec'd read register would be 0.
    logic          id_ok_reg;
    logic          rd_ok_reg;
    logic [DW-1:0] imem_q_reg;
    logic [DW-1:0] dmem_q_reg;

    logic [DW-1:0] imem_mem [DEPTH];
    logic [DW-1:0] dmem_mem [DEPTH];

    // Range checks use the full 16-bit address. Only the low AW bits index memory.
    logic ia_oor;
    logic da_oor;
    logic in_run;
    assign ia_oor = |IA[15:AW];
    assign da_oor = |DA[15:AW];
    assign in_run = (state_reg == ST_RUN);

    // Single write port per memory. The sources are CLEAR, host load,
    // and CPU store; only one of them is active in any given state.
    logic          imem_we;
    logic [AW-1:0] imem_wa;
    logic [DW-1:0] imem_wd;
    logic          dmem_we;
    logic [AW-1:0] dmem_wa;
    logic [DW-1:0] dmem_wd;

    always_comb begin
        imem_we = 1'b0;
        imem_wa = LD_ADDR;
        imem_wd = LD_DATA;
        dmem_we = 1'b0;
        dmem_wa = LD_ADDR;
        dmem_wd = LD_DATA;
        case (state_reg)
            ST_CLEAR: begin
                imem_we = 1'b1;
                imem_wa = clr_cnt_reg;
                imem_wd = '0;
                dmem_we = 1'b1;
                dmem_wa = clr_cnt_reg;
                dmem_wd = '0;
            end
            ST_LOAD: begin
                imem_we = LD_VALID && !LD_SEL;
                dmem_we = LD_VALID && LD_SEL;
            end
            ST_RUN: begin
                dmem_we = !RW && !da_oor;
                dmem_wa = DA[AW-1:0];
                dmem_wd = DD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CK) begin
        if (imem_we) begin
            imem_mem[imem_wa] <= imem_wd;
        end
        if (dmem_we) begin
            dmem_mem[dmem_wa] <= dmem_wd;
        end
        if (in_run) begin
            imem_q_reg <= imem_mem[IA[AW-1:0]];
        end
        // Reads and writes are exclusive on RW, so a read on the cycle
        // after a store returns the freshly written word.
        if (in_run && RW) begin
            dmem_q_reg <= dmem_mem[DA[AW-1:0]];
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_reg    <= ST_CLEAR;
            clr_cnt_reg  <= '0;
            ld_ready_reg <= 1'b0;
            cpu_rst_reg  <= 1'b1;
            err_reg      <= 1'b0;
            id_ok_reg    <= 1'b0;
            rd_ok_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    // The counter wraps back to 0 on the last clear cycle.
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (&clr_cnt_reg) begin
                        state_reg    <= ST_LOAD;
                        ld_ready_reg <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (LD_DONE) begin
                        state_reg    <= ST_RUN;
                        ld_ready_reg <= 1'b0;
                        cpu_rst_reg  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (LD_START) begin
                        state_reg    <= ST_LOAD;
                        ld_ready_reg <= 1'b1;
                        cpu_rst_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= ST_CLEAR;
                    clr_cnt_reg  <= '0;
                    ld_ready_reg <= 1'b0;
                    cpu_rst_reg  <= 1'b1;
                end
            endcase

            if (in_run && (ia_oor || da_oor)) begin
                err_reg <= 1'b1;
            end

            id_ok_reg <= in_run && !ia_oor;

            // The read register holds its value across CPU write cycles.
            // It is forced to 0 outside RUN.
            if (!in_run) begin
                rd_ok_reg <= 1'b0;
            end else if (RW) begin
                rd_ok_reg <= !da_oor;
            end
        end
    end

    logic [DW-1:0] rd_data;
    assign rd_data = rd_ok_reg ? dmem_q_reg : '0;

    assign ID       = id_ok_reg ? imem_q_reg : '0;
    assign DD       = RW ? rd_data : {DW{1'bz}};
    assign LD_READY = ld_ready_reg;
    assign CPU_RST  = cpu_rst_reg;
    assign ERR      = err_reg;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Testbench for cpu_mem_responder. It uses a behavioural reference model.
// Every cycle, a compare process checks the DUT against the model.
// Directed steps add hand-computed literal checks.
module tb_cpu_mem_responder;

    logic        CK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] IA = '0;
    logic [15:0] ID;
    logic [15:0] DA = '0;
    wire  [15:0] DD;
    logic        RW = 1'b1;
    logic        LD_VALID = 1'b0;
    logic        LD_SEL = 1'b0;
    logic [6:0]  LD_ADDR = '0;
    logic [15:0] LD_DATA = '0;
    logic        LD_READY;
    logic        LD_DONE = 1'b0;
    logic        LD_START = 1'b0;
    logic        CPU_RST;
    logic        ERR;

    logic [15:0] tb_dd = '0;
    assign DD = RW ? 16'hzzzz : tb_dd;

    always #5 CK = ~CK;

    cpu_mem_responder #(.AW(7), .DW(16)) dut (
        .CK(CK), .RST(RST), .IA(IA), .ID(ID), .DA(DA), .DD(DD), .RW(RW),
        .LD_VALID(LD_VALID), .LD_SEL(LD_SEL), .LD_ADDR(LD_ADDR),
        .LD_DATA(LD_DATA), .LD_READY(LD_READY), .LD_DONE(LD_DONE),
        .LD_START(LD_START), .CPU_RST(CPU_RST), .ERR(ERR)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 = clearing, 1 = loading, 2 = running.
    int          m_state = 0;
    int          m_cnt = 0;
    logic [15:0] m_imem [128];
    logic [15:0] m_dmem [128];
    logic [15:0] m_id = '0;
    logic [15:0] m_rd = '0;
    logic        m_err = 1'b0;
    logic        m_was_run;

    initial forever begin
        @(posedge CK or posedge RST);
        if (RST) begin
            m_state = 0;
            m_cnt   = 0;
            m_id    = '0;
            m_rd    = '0;
            m_err   = 1'b0;
        end else begin
            m_was_run = (m_state == 2);
            if (m_state == 0) begin
                m_imem[m_cnt[6:0]] = '0;
                m_dmem[m_cnt[6:0]] = '0;
                m_cnt++;
                if (m_cnt == 128) begin
                    m_cnt   = 0;
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                if (LD_VALID) begin
                    if (LD_SEL) m_dmem[LD_ADDR] = LD_DATA;
                    else        m_imem[LD_ADDR] = LD_DATA;
                end
                if (LD_DONE) m_state = 2;
            end else begin
                if (IA >= 16'd128) begin
                    m_id  = '0;
                    m_err = 1'b1;
                end else begin
                    m_id = m_imem[IA[6:0]];
                end
                if (RW) begin
                    if (DA >= 16'd128) begin
                        m_rd  = '0;
                        m_err = 1'b1;
                    end else begin
                        m_rd = m_dmem[DA[6:0]];
                    end
                end else begin
                    if (DA >= 16'd128) m_err = 1'b1;
                    else               m_dmem[DA[6:0]] = tb_dd;
                end
                if (LD_START) m_state = 1;
            end
            if (!m_was_run) begin
                m_id = '0;
                m_rd = '0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge CK);
        #2;
        check("cpu_rst", 16'(CPU_RST), 16'(m_state != 2));
        check("ld_ready", 16'(LD_READY), 16'(m_state == 1));
        check("id", ID, m_id);
        check("err", 16'(ERR), 16'(m_err));
        if (RW) check("dd_read", DD, m_rd);
        else    check("dd_write_bus", DD, tb_dd);
    end

    // ---------------- stimulus ----------------
    logic [15:0] prog [13] = '{16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04, 16'h1105,
                               16'h2106, 16'h3107, 16'h0112, 16'h4208, 16'h5309,
                               16'h640A, 16'h750B, 16'hF00C};

    task automatic tick();
        @(negedge CK);
        LD_VALID = 1'b0;
        LD_DONE  = 1'b0;
        LD_START = 1'b0;
    endtask

    // Runs the 128 clear cycles that follow a reset release at a negedge.
    task automatic clear_wait();
        for (int i = 1; i <= 128; i++) begin
            tick();
            if (i == 127) begin
                #3;
                check("clear_ready_127", 16'(LD_READY), 16'h0);
            end
            if (i == 128) begin
                #3;
                check("clear_ready_128", 16'(LD_READY), 16'h1);
                check("clear_cpu_rst", 16'(CPU_RST), 16'h1);
            end
        end
    endtask

    task automatic load_word(input logic sel, input logic [6:0] addr,
                             input logic [15:0] data, input logic done);
        tick();
        LD_VALID = 1'b1;
        LD_SEL   = sel;
        LD_ADDR  = addr;
        LD_DATA  = data;
        LD_DONE  = done;
    endtask

    task automatic cpu(input logic rw, input logic [15:0] ia, input logic [15:0] da,
                       input logic [15:0] dd);
        tick();
        RW    = rw;
        IA    = ia;
        DA    = da;
        tb_dd = dd;
    endtask

    initial begin
        #1 RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        $display("step: reset released, clearing");

        // Reset 40 cycles into CLEAR, so the clear must restart from 0.
        repeat (40) tick();
        RST = 1'b1;
        #1;
        check("rst40_cpu_rst", 16'(CPU_RST), 16'h1);
        check("rst40_ready", 16'(LD_READY), 16'h0);
        tick();
        RST = 1'b0;
        clear_wait();
        $display("step: clear after mid-clear reset done");

        // Partial load, then reset during LOAD: the words are lost.
        load_word(1'b1, 7'd20, 16'hBEEF, 1'b0);
        load_word(1'b0, 7'd3, 16'h7777, 1'b0);
        tick();
        RST = 1'b1;
        #1;
        check("rstload_ready", 16'(LD_READY), 16'h0);
        check("rstload_cpu_rst", 16'(CPU_RST), 16'h1);
        tick();
        RST = 1'b0;
        clear_wait();
        $display("step: clear after load-phase reset done");

        // LD_START in LOAD is ignored.
        tick();
        LD_START = 1'b1;
        for (int i = 0; i < 13; i++) load_word(1'b0, 7'(i), prog[i], 1'b0);
        load_word(1'b1, 7'd5, 16'h0042, 1'b1);
        tick();
        RW = 1'b1; IA = 16'd7; DA = 16'd5;
        #3;
        check("run_cpu_rst_low", 16'(CPU_RST), 16'h0);
        check("run_ready_low", 16'(LD_READY), 16'h0);
        tick();
        #3;
        check("id_ia7", ID, 16'h0112);
        check("dd_da5", DD, 16'h0042);
        $display("step: program loaded, fetch IA=7 and read DA=5");

        // Words that were not loaded must read 0, including the one lost to reset.
        cpu(1'b1, 16'd100, 16'd20, 16'h0000);
        tick();
        #3;
        check("id_unloaded", ID, 16'h0000);
        check("dd_lost_word", DD, 16'h0000);
        cpu(1'b1, 16'd3, 16'd5, 16'h0000);
        tick();
        #3;
        check("id_reloaded3", ID, 16'h0D04);

        // Store, then read back on the next cycle.
        cpu(1'b0, 16'd0, 16'd5, 16'h1234);
        #3;
        check("dd_bus_write", DD, 16'h1234);
        cpu(1'b1, 16'd0, 16'd5, 16'h0000);
        tick();
        #3;
        check("raw_da5", DD, 16'h1234);
        cpu(1'b0, 16'd12, 16'd127, 16'hA5A5);
        cpu(1'b1, 16'd127, 16'd127, 16'h0000);
        tick();
        #3;
        check("raw_da127", DD, 16'hA5A5);
        check("id_ia127", ID, 16'h0000);
        check("err_still_0", 16'(ERR), 16'h0);
        $display("step: store and read-after-write");

        // Out-of-range accesses.
        cpu(1'b1, 16'h0080, 16'd5, 16'h0000);
        tick();
        #3;
        check("id_oor", ID, 16'h0000);
        check("err_oor", 16'(ERR), 16'h1);
        cpu(1'b0, 16'd1, 16'h00FF, 16'h5555);
        cpu(1'b0, 16'd1, 16'h0085, 16'h9999);
        cpu(1'b1, 16'd1, 16'd127, 16'h0000);
        cpu(1'b1, 16'd1, 16'd5, 16'h0000);
        #3;
        check("oor_no_alias127", DD, 16'hA5A5);
        tick();
        #3;
        check("oor_no_alias5", DD, 16'h1234);
        cpu(1'b1, 16'd1, 16'h8005, 16'h0000);
        tick();
        #3;
        check("dd_oor_read", DD, 16'h0000);
        $display("step: out-of-range accesses");

        // LD_DONE is ignored in RUN. LD_START returns to LOAD.
        tick();
        LD_DONE = 1'b1;
        tick();
        LD_START = 1'b1;
        tick();
        #3;
        check("ldstart_cpu_rst", 16'(CPU_RST), 16'h1);
        check("ldstart_ready", 16'(LD_READY), 16'h1);
        load_word(1'b0, 7'd8, 16'hCAFE, 1'b1);
        cpu(1'b1, 16'd8, 16'd5, 16'h0000);
        tick();
        #3;
        check("kept_da5", DD, 16'h1234);
        check("new_ia8", ID, 16'hCAFE);
        check("err_sticky", 16'(ERR), 16'h1);
        $display("step: reload cycle, contents kept");

        tick();
        RST = 1'b1;
        #1;
        check("final_rst_err", 16'(ERR), 16'h0);
        check("final_rst_id", ID, 16'h0000);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
